mem_arbiter: RTL

//  Upstream of the MMU: serialises the CPU's instruction-fetch and load/store requests onto the MMU's

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store requests onto the MMU's single access port.
// Data requests win over fetches; each access is held for ACCESS_CYCLES clocks.
module mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_err,
    output logic        stall,
    output logic        mmu_read,
    output logic        mmu_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic        mmu_bytemode,
    input  logic [31:0] mmu_rdata
);

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mmu_read_q, mmu_read_d;
    logic        mmu_write_q, mmu_write_d;
    logic [31:0] mmu_addr_q, mmu_addr_d;
    logic [31:0] mmu_wdata_q, mmu_wdata_d;
    logic        mmu_bytemode_q, mmu_bytemode_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_err_q, mem_err_d;

    logic mem_elig, if_elig, mem_misaligned;

    // A requester still holding req during its valid pulse must not be relaunched.
    assign mem_elig       = mem_req & ~mem_valid_q;
    assign if_elig        = if_req & ~if_valid_q;
    assign mem_misaligned = ~mem_byte & (mem_addr[1:0] != 2'b00);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        mmu_read_d     = mmu_read_q;
        mmu_write_d    = mmu_write_q;
        mmu_addr_d     = mmu_addr_q;
        mmu_wdata_d    = mmu_wdata_q;
        mmu_bytemode_d = mmu_bytemode_q;
        if_rdata_d     = if_rdata_q;
        mem_rdata_d    = mem_rdata_q;
        if_valid_d     = 1'b0;
        mem_valid_d    = 1'b0;
        mem_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_elig) begin
                    if (mem_misaligned) begin
                        mem_valid_d = 1'b1;
                        mem_err_d   = 1'b1;
                    end else begin
                        state_d        = ACCESS;
                        owner_d        = OWN_D;
                        cnt_d          = '0;
                        mmu_addr_d     = mem_addr;
                        mmu_wdata_d    = mem_wdata;
                        mmu_bytemode_d = mem_byte;
                        mmu_read_d     = ~mem_we;
                        mmu_write_d    = mem_we;
                    end
                end else if (if_elig) begin
                    state_d        = ACCESS;
                    owner_d        = OWN_I;
                    cnt_d          = '0;
                    mmu_addr_d     = if_addr;
                    mmu_bytemode_d = 1'b0;
                    mmu_read_d     = 1'b1;
                    mmu_write_d    = 1'b0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    mmu_read_d  = 1'b0;
                    mmu_write_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        mem_valid_d = 1'b1;
                        if (mmu_read_q) begin
                            mem_rdata_d = mmu_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mmu_rdata;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_I;
            cnt_q          <= '0;
            mmu_read_q     <= 1'b0;
            mmu_write_q    <= 1'b0;
            mmu_addr_q     <= '0;
            mmu_wdata_q    <= '0;
            mmu_bytemode_q <= 1'b0;
            if_rdata_q     <= '0;
            if_valid_q     <= 1'b0;
            mem_rdata_q    <= '0;
            mem_valid_q    <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            mmu_read_q     <= mmu_read_d;
            mmu_write_q    <= mmu_write_d;
            mmu_addr_q     <= mmu_addr_d;
            mmu_wdata_q    <= mmu_wdata_d;
            mmu_bytemode_q <= mmu_bytemode_d;
            if_rdata_q     <= if_rdata_d;
            if_valid_q     <= if_valid_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_valid_q    <= mem_valid_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign stall        = (if_req & ~if_valid_q) | (mem_req & ~mem_valid_q);
    assign if_rdata     = if_rdata_q;
    assign if_valid     = if_valid_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_valid    = mem_valid_q;
    assign mem_err      = mem_err_q;
    assign mmu_read     = mmu_read_q;
    assign mmu_write    = mmu_write_q;
    assign mmu_addr     = mmu_addr_q;
    assign mmu_wdata    = mmu_wdata_q;
    assign mmu_bytemode = mmu_bytemode_q;

endmodule
